// File: rtl/lfsr_checker_pkg.sv
// Shared types and the XNOR Fibonacci next-state function for the LFSR checker.
package lfsr_checker_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } state_t;

  localparam logic [31:0] DEFAULT_TAPS = 32'h0000_00B8;

  // Callers zero-extend x and taps to 32 bits and truncate the result to their width.
  function automatic logic [31:0] lfsr_next(input logic [31:0] x, input logic [31:0] taps);
    return {x[30:0], ~^(x & taps)};
  endfunction

endpackage

// File: rtl/lfsr_checker_cmp.sv
// Per-bit masked compare of a received word against the predicted word.
module lfsr_checker_cmp #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] mask,
  output logic             match
);

  logic [WIDTH-1:0] diff;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign diff[i] = mask[i] & (a[i] ^ b[i]);
  end

  assign match = ~|diff;

endmodule

// File: rtl/lfsr_checker.sv
// Locks a predictor onto a received XNOR LFSR stream and counts mismatches once locked.
// Define LFSR_CHECKER_OE_MASK_EN to exclude bits with in_oe=0 from comparison.
module lfsr_checker
  import lfsr_checker_pkg::*;
#(
  parameter int             WIDTH    = 8,
  parameter logic [WIDTH-1:0] TAPS   = WIDTH'(DEFAULT_TAPS),
  parameter int             LOCK_CNT = 4,
  parameter int             MAX_MISS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_oe,
  output logic             locked,
  output logic             err,
  output logic [15:0]      err_cnt,
  output logic [WIDTH-1:0] expected,
  output logic [1:0]       state
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
  localparam logic [3:0] MISS_N = 4'(MAX_MISS);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pred_q, pred_d, nxt, mask, load_val;
  logic [3:0]       match_q, match_d, miss_q, miss_d;
  logic             reseed_q, reseed_d;
  logic             err_q, err_d, locked_q;
  logic [15:0]      err_cnt_q, err_cnt_d;
  logic             eff_valid, all_ones, match;

`ifdef LFSR_CHECKER_OE_MASK_EN
  assign mask      = in_oe;
  assign eff_valid = in_valid & (|in_oe);
`else
  logic unused_oe;
  assign unused_oe = ^in_oe;
  assign mask      = '1;
  assign eff_valid = in_valid;
`endif

  assign nxt      = WIDTH'(lfsr_next(32'(pred_q), 32'(TAPS)));
  assign all_ones = &in_data;
  // Masked bits carry the prediction forward so the predictor stays a legal LFSR state.
  assign load_val = (in_data & mask) | (nxt & ~mask);

  lfsr_checker_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a     (in_data),
    .b     (nxt),
    .mask  (mask),
    .match (match)
  );

  always_comb begin
    state_d   = state_q;
    pred_d    = pred_q;
    match_d   = match_q;
    miss_d    = miss_q;
    reseed_d  = reseed_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (eff_valid && !all_ones) begin
          pred_d  = in_data;
          match_d = '0;
          state_d = ACQUIRE;
        end
      end
      ACQUIRE: begin
        if (eff_valid && !all_ones) begin
          if (reseed_q) begin
            // First sample after a fault only seeds; there is no trusted prediction yet.
            pred_d   = in_data;
            match_d  = '0;
            reseed_d = 1'b0;
          end else if (match) begin
            pred_d  = load_val;
            match_d = match_q + 4'd1;
            if (match_q + 4'd1 == LOCK_N) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else begin
            pred_d  = load_val;
            match_d = '0;
          end
        end
      end
      LOCKED: begin
        if (eff_valid) begin
          pred_d = nxt;
          if (match) begin
            miss_d = '0;
          end else begin
            err_d  = 1'b1;
            miss_d = miss_q + 4'd1;
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            if (miss_q + 4'd1 == MISS_N) state_d = FAULT;
          end
        end
      end
      FAULT: begin
        state_d  = ACQUIRE;
        match_d  = '0;
        reseed_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pred_q    <= '0;
      match_q   <= '0;
      miss_q    <= '0;
      reseed_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pred_q    <= pred_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      reseed_q  <= reseed_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      locked_q  <= (state_d == LOCKED);
    end
  end

  assign locked   = locked_q;
  assign err      = err_q;
  assign err_cnt  = err_cnt_q;
  assign expected = pred_q;
  assign state    = state_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Randomized bench for lfsr_checker with a sample-level behavioural reference model.
module tb_lfsr_checker;

  localparam int         W        = 8;
  localparam int         LOCK_CNT = 4;
  localparam int         MAX_MISS = 3;
  localparam logic [7:0] TAPS     = 8'hB8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data, in_oe;
  logic        locked, err;
  logic [15:0] err_cnt;
  logic [7:0]  expected;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: state 0 idle, 1 acquire, 2 locked, 3 fault
  int         m_state, m_cnt, m_miss, m_errc;
  logic [7:0] m_pred;
  bit         m_err, m_reseed;
  logic [7:0] tx;

  lfsr_checker #(.WIDTH(W), .TAPS(TAPS), .LOCK_CNT(LOCK_CNT), .MAX_MISS(MAX_MISS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_oe    (in_oe),
    .locked   (locked),
    .err      (err),
    .err_cnt  (err_cnt),
    .expected (expected),
    .state    (state)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_next(input logic [7:0] x);
    int ones;
    ones = $countones(x & TAPS);
    return {x[6:0], ~ones[0]};
  endfunction

  function automatic logic [7:0] rand_seed();
    logic [7:0] s;
    s = 8'($urandom);
    if (s == 8'hff) s = 8'h5a;
    return s;
  endfunction

  function automatic logic [27:0] dut_vec();
    return {state, locked, err, err_cnt, expected};
  endfunction

  function automatic logic [27:0] ref_vec();
    return {2'(m_state), (m_state == 2), m_err, 16'(m_errc), m_pred};
  endfunction

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_miss = 0; m_errc = 0;
    m_pred = 8'h00; m_err = 0; m_reseed = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input logic [7:0] oe);
    bit         eff, hit;
    logic [7:0] msk, n;
`ifdef LFSR_CHECKER_OE_MASK_EN
    eff = v && (oe != 8'h00);
    msk = oe;
`else
    eff = v;
    msk = 8'hff;
`endif
    n     = ref_next(m_pred);
    hit   = ((d ^ n) & msk) == 8'h00;
    m_err = 0;
    case (m_state)
      0: if (eff && d != 8'hff) begin m_pred = d; m_cnt = 0; m_state = 1; end
      1: if (eff && d != 8'hff) begin
           if (m_reseed) begin m_pred = d; m_reseed = 0; m_cnt = 0; end
           else begin
             m_pred = (d & msk) | (n & ~msk);
             m_cnt  = hit ? m_cnt + 1 : 0;
             if (m_cnt == LOCK_CNT) begin m_state = 2; m_miss = 0; end
           end
         end
      2: if (eff) begin
           m_pred = n;
           if (hit) m_miss = 0;
           else begin
             m_err  = 1;
             m_errc = (m_errc < 65535) ? m_errc + 1 : 65535;
             m_miss++;
             if (m_miss == MAX_MISS) m_state = 3;
           end
         end
      default: begin m_state = 1; m_reseed = 1; m_cnt = 0; end
    endcase
  endtask

  task automatic cycle(input bit v, input logic [7:0] d, input logic [7:0] oe);
    in_valid = v; in_data = d; in_oe = oe;
    @(posedge clk);
    #1;
    model_step(v, d, oe);
  endtask

  // stimulus only: fresh seed followed by LOCK_CNT correct words
  task automatic lock_up();
    tx = rand_seed();
    cycle(1'b1, tx, 8'hff);
    repeat (LOCK_CNT) begin
      tx = ref_next(tx);
      cycle(1'b1, tx, 8'hff);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hed; in_oe = 8'hff;
    model_reset();
    @(posedge clk);
    #1;
    n_cmp++;
    if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++;
    if ({locked, err} !== 2'b00) begin n_bad++; $display("FAIL reset_flags: got %b want 00", {locked, err}); end
    n_cmp++;
    if (err_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_err_cnt: got %h want 0000", err_cnt); end
    n_cmp++;
    if (expected !== 8'h00) begin n_bad++; $display("FAIL reset_expected: got %h want 00", expected); end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
  endtask

  task automatic test_idle_ff();
    cycle(1'b1, 8'hff, 8'hff);
    n_cmp++;
    if ({state, expected} !== {2'd0, 8'h00}) begin
      n_bad++; $display("FAIL idle_ff_ignored: got state %0d pred %h want 0 00", state, expected);
    end
    cycle(1'b1, 8'hed, 8'hff);
    tx = 8'hed;
    n_cmp++;
    if ({state, expected} !== {2'd1, 8'hed}) begin
      n_bad++; $display("FAIL idle_seed: got state %0d pred %h want 1 ed", state, expected);
    end
  endtask

  task automatic test_lock();
    for (int i = 0; i < LOCK_CNT; i++) begin
      tx = ref_next(tx);
      cycle(1'b1, tx, 8'hff);
      n_cmp++;
      if (state !== ((i == LOCK_CNT - 1) ? 2'd2 : 2'd1) || locked !== (i == LOCK_CNT - 1)) begin
        n_bad++; $display("FAIL lock_progress[%0d]: got state %0d locked %b", i, state, locked);
      end
      n_cmp++;
      if (expected !== tx) begin n_bad++; $display("FAIL lock_expected[%0d]: got %h want %h", i, expected, tx); end
    end
    n_cmp++;
    if (ref_next(8'hed) !== 8'hda || ref_next(8'hda) !== 8'hb4) begin
      n_bad++; $display("FAIL ref_sequence: got %h %h want da b4", ref_next(8'hed), ref_next(8'hda));
    end
    for (int i = 0; i < 6; i++) begin
      bit v;
      v = (i % 2) == 0;
      if (v) tx = ref_next(tx);
      cycle(v, v ? tx : 8'($urandom), 8'hff);
      n_cmp++;
      if (dut_vec() !== ref_vec() || expected !== tx) begin
        n_bad++; $display("FAIL flywheel[%0d]: got %h want %h", i, dut_vec(), ref_vec());
      end
    end
  endtask

  task automatic test_err();
    tx = ref_next(tx);
    cycle(1'b1, tx ^ 8'h01, 8'hff);
    n_cmp++;
    if ({err, err_cnt, locked} !== {1'b1, 16'd1, 1'b1}) begin
      n_bad++; $display("FAIL err_pulse: got err %b cnt %0d locked %b want 1 1 1", err, err_cnt, locked);
    end
    tx = ref_next(tx);
    cycle(1'b1, tx, 8'hff);
    n_cmp++;
    if ({err, err_cnt, locked, expected} !== {1'b0, 16'd1, 1'b1, tx}) begin
      n_bad++; $display("FAIL err_recover: got err %b cnt %0d locked %b pred %h want 0 1 1 %h",
                        err, err_cnt, locked, expected, tx);
    end
  endtask

  task automatic test_fault();
    for (int i = 0; i < MAX_MISS; i++) begin
      tx = ref_next(tx);
      cycle(1'b1, tx ^ 8'h80, 8'hff);
      n_cmp++;
      if (state !== ((i == MAX_MISS - 1) ? 2'd3 : 2'd2) || err !== 1'b1) begin
        n_bad++; $display("FAIL fault_miss[%0d]: got state %0d err %b", i, state, err);
      end
    end
    n_cmp++;
    if ({locked, err_cnt} !== {1'b0, 16'd4}) begin
      n_bad++; $display("FAIL fault_flags: got locked %b cnt %0d want 0 4", locked, err_cnt);
    end
    cycle(1'b0, 8'h00, 8'hff);
    n_cmp++;
    if (state !== 2'd1) begin n_bad++; $display("FAIL fault_to_acquire: got %0d want 1", state); end
    lock_up();
    n_cmp++;
    if (dut_vec() !== ref_vec() || state !== 2'd2) begin
      n_bad++; $display("FAIL relock: got %h want %h", dut_vec(), ref_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bit         v;
      int         r;
      logic [7:0] d;
      v = $urandom_range(0, 3) != 0;
      r = $urandom_range(0, 24);
      d = 8'($urandom);
      if (v) begin
        if (r == 2) tx = rand_seed();
        else tx = ref_next(tx);
        d = (r == 0) ? tx ^ (8'h01 << $urandom_range(0, 7)) : (r == 1) ? 8'hff : tx;
      end
      cycle(v, d, (r < 12) ? 8'($urandom) : 8'hff);
      n_cmp++;
      if (dut_vec() !== ref_vec()) begin
        n_bad++; $display("FAIL random[%0d]: got %h want %h", i, dut_vec(), ref_vec());
      end
    end
  endtask

  task automatic test_reset_locked();
    rst_n = 1'b0; #1; rst_n = 1'b1; model_reset();
    lock_up();
    for (int i = 0; i < 5; i++) begin
      tx = ref_next(tx);
      cycle(1'b1, tx ^ 8'h01, 8'hff);
      if (i < 4) begin tx = ref_next(tx); cycle(1'b1, tx, 8'hff); end
    end
    n_cmp++;
    if ({locked, err, err_cnt} !== {1'b1, 1'b1, 16'd5}) begin
      n_bad++; $display("FAIL pre_reset: got locked %b err %b cnt %0d want 1 1 5", locked, err, err_cnt);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({state, locked, err, err_cnt, expected} !== 28'h0) begin
      n_bad++; $display("FAIL async_reset: got %h want 0000000", dut_vec());
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 8'h00, 8'hff);
    n_cmp++;
    if (dut_vec() !== ref_vec()) begin n_bad++; $display("FAIL post_reset: got %h want %h", dut_vec(), ref_vec()); end
  endtask

  task automatic test_oe();
    logic [7:0] held;
    logic [15:0] cnt0;
    lock_up();
    cnt0 = err_cnt;
    tx = ref_next(tx);
    cycle(1'b1, tx ^ 8'hf0, 8'h0f);
`ifdef LFSR_CHECKER_OE_MASK_EN
    n_cmp++;
    if ({err, err_cnt, expected} !== {1'b0, cnt0, tx}) begin
      n_bad++; $display("FAIL oe_masked: got err %b cnt %0d pred %h want 0 %0d %h", err, err_cnt, expected, cnt0, tx);
    end
    held = expected;
    cycle(1'b1, 8'h3c, 8'h00);
    n_cmp++;
    if ({state, expected} !== {2'd2, held}) begin
      n_bad++; $display("FAIL oe_zero_ignored: got state %0d pred %h want 2 %h", state, expected, held);
    end
`else
    n_cmp++;
    if ({err, err_cnt} !== {1'b1, cnt0 + 16'd1}) begin
      n_bad++; $display("FAIL oe_ignored_cmp: got err %b cnt %0d want 1 %0d", err, err_cnt, cnt0 + 16'd1);
    end
    tx = ref_next(tx);
    held = tx;
    cycle(1'b1, tx, 8'h00);
    n_cmp++;
    if ({err, expected} !== {1'b0, held}) begin
      n_bad++; $display("FAIL oe_zero_sampled: got err %b pred %h want 0 %h", err, expected, held);
    end
`endif
    n_cmp++;
    if (dut_vec() !== ref_vec()) begin n_bad++; $display("FAIL oe_model: got %h want %h", dut_vec(), ref_vec()); end
  endtask

  initial begin
    test_reset();
    test_idle_ff();
    test_lock();
    test_err();
    test_fault();
    test_random();
    test_reset_locked();
    test_oe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
